median_window_filter: RTL and testbench
=======================================

MEDIAN_WINDOW_FILTER -- requirements
Module: median_window_filter

Interface
REQ-001 Parameter IMG_WIDTH, default 256: pixels per image row.
REQ-002 Parameter IMG_HEIGHT, default 256: rows per frame.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 nres  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  the three row taps carry a valid column this cycle.
REQ-006 sof  input  1  start of frame; meaningful only with in_valid.
REQ-007 px_top  input  8  pixel from two rows above the current row, from the second line-buffer output.
REQ-008 px_mid  input  8  pixel from one row above, from the first line-buffer output.
REQ-009 px_bot  input  8  pixel of the current row, the live input stream.
REQ-010 out_valid  output  1  out_data holds a filtered pixel this cycle.
REQ-011 out_data  output  8  filtered pixel.

Function
REQ-012 The block SHALL keep a 3x3 window of 3 columns x 3 taps; the window SHALL shift by one column only on cycles where in_valid=1, with the new column taken from {px_top, px_mid, px_bot}.
REQ-013 The block SHALL keep a column counter (0..IMG_WIDTH-1) and a row counter (0..IMG_HEIGHT-1) that advance once per accepted column.
- Column wraps to 0 at IMG_WIDTH-1 and increments the row.
- Row wraps to 0 after the last column of row IMG_HEIGHT-1.
REQ-014 If in_valid=1 and sof=1, the accepted column SHALL be counted as (row 0, col 0), regardless of the current counter values; sof with in_valid=0 SHALL be ignored.
REQ-015 A window SHALL be complete only when the accepted column has col>=2 and row>=2. Only complete windows SHALL produce out_valid=1, giving exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) outputs per frame.
REQ-016 Median datapath, all unsigned 8-bit compares, one register stage each:
- S1: sort each column into min/med/max.
- S2: max of the three column mins, median of the three column meds, min of the three column maxes.
- S3: median of those three values.
- S4: output select and output register.
REQ-017 The window centre pixel (middle tap of the middle column) SHALL be carried alongside the pipeline unchanged.
REQ-018 S4 select rule: out_data = median when centre == NOISE_LO (0) or centre == NOISE_HI (255); otherwise out_data = centre.
REQ-019 Latency: for a column accepted at rising edge k that completes a window, out_valid and out_data SHALL be updated at edge k+4.
REQ-020 The pipeline SHALL advance every cycle with no backpressure. Gaps in in_valid SHALL propagate as out_valid=0 bubbles, and the data values produced SHALL be independent of gap placement.
REQ-021 out_valid SHALL be a single-cycle pulse per result. out_data SHALL hold its last value while out_valid=0.

Reset
REQ-022 While nres=0, the block SHALL immediately force the following to 0: out_valid, out_data, all pipeline valid bits, the window registers, and both counters.
REQ-023 Reset asserted mid-frame SHALL discard all in-flight results; no out_valid SHALL appear after release until a new complete window has traversed the full latency.
REQ-024 After reset release, the first accepted column SHALL be treated as (row 0, col 0) even when sof=0.

Structure
REQ-025 A shared package spn_pkg SHALL hold: pixel_t (8-bit unsigned), NOISE_LO, NOISE_HI, and the default IMG_WIDTH/IMG_HEIGHT values.
REQ-026 A combinational sub-module sort3 (three 8-bit inputs -> min, med, max) SHALL be used, instantiated for S1, S2 and S3.

Verification
REQ-027 Reset: drive nres=0 during row 5 with results in flight -> out_valid=0 and out_data=0 immediately; no out_valid within 4 cycles after release.
REQ-028 Flat frame: IMG_WIDTH=IMG_HEIGHT=4, all pixels 100, continuous in_valid, sof on the first column -> exactly 4 pulses of out_data=100, the first at edge k+4 after the column at (row 2, col 2).
REQ-029 Salt centre: window columns {10,40,70}, {20,255,80}, {30,60,90} -> out_data=60.
REQ-030 Clean centre: same window with centre 50 -> out_data=50 (passthrough); centre 0 with all neighbours 200 -> out_data=200.
REQ-031 Gaps: the REQ-028 frame with in_valid toggling every other cycle -> same 4 values in the same order, each out_valid 4 edges after its completing column.
REQ-032 Resync: sof asserted at (row 3, col 1) of a 6x6 frame -> no out_valid until the column counted as (row 2, col 2) after resync; then 16 outputs for that frame.

Source files
------------

// File: rtl/spn_pkg.sv
// Shared types and constants for the 3x3 salt-and-pepper median filter.
package spn_pkg;

  typedef logic [7:0] pixel_t;

  localparam pixel_t NOISE_LO = 8'd0;
  localparam pixel_t NOISE_HI = 8'd255;

  localparam int DEF_IMG_WIDTH  = 256;
  localparam int DEF_IMG_HEIGHT = 256;

  typedef struct packed {
    pixel_t top;
    pixel_t mid;
    pixel_t bot;
  } col_t;

  function automatic logic is_noise(pixel_t p);
    return (p == NOISE_LO) || (p == NOISE_HI);
  endfunction

endpackage

// File: rtl/sort3.sv
// Combinational three-input sorter: unsigned min, median and max.
module sort3
  import spn_pkg::*;
(
  input  pixel_t a_i,
  input  pixel_t b_i,
  input  pixel_t c_i,
  output pixel_t min_o,
  output pixel_t med_o,
  output pixel_t max_o
);

  pixel_t lo;
  pixel_t hi;

  always_comb begin
    lo    = (a_i < b_i) ? a_i : b_i;
    hi    = (a_i < b_i) ? b_i : a_i;
    min_o = (c_i < lo) ? c_i : lo;
    max_o = (c_i > hi) ? c_i : hi;
    if (c_i < lo) begin
      med_o = lo;
    end else if (c_i > hi) begin
      med_o = hi;
    end else begin
      med_o = c_i;
    end
  end

endmodule

// File: rtl/median_window_filter.sv
// 3x3 window median filter that replaces only 0/255 centre pixels.
// Four register stages from accepted column to output.
module median_window_filter
  import spn_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic   clk,
  input  logic   nres,
  input  logic   in_valid,
  input  logic   sof,
  input  pixel_t px_top,
  input  pixel_t px_mid,
  input  pixel_t px_bot,
  output logic   out_valid,
  output pixel_t out_data
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic [CW-1:0] col_q, col_d, pos_col;
  logic [RW-1:0] row_q, row_d, pos_row;

  col_t [2:0] win_q, win_d;
  logic       v0_q, v0_d;

  pixel_t [2:0] s1_min_d, s1_med_d, s1_max_d;
  pixel_t [2:0] s1_min_q, s1_med_q, s1_max_q;
  pixel_t       s1_cen_q;
  logic         s1_v_q;

  pixel_t s2_lo_d, s2_md_d, s2_hi_d;
  pixel_t s2_lo_q, s2_md_q, s2_hi_q;
  pixel_t s2_cen_q;
  logic   s2_v_q;

  pixel_t s3_med_d, s3_med_q;
  pixel_t s3_cen_q;
  logic   s3_v_q;

  logic   out_valid_q, out_valid_d;
  pixel_t out_data_q, out_data_d;

  pixel_t unused_s2a_mn, unused_s2a_md;
  pixel_t unused_s2b_mn, unused_s2b_mx;
  pixel_t unused_s2c_md, unused_s2c_mx;
  pixel_t unused_s3_mn, unused_s3_mx;

  // sof forces the accepted column to (0,0); counters hold the next position
  always_comb begin
    pos_col = sof ? '0 : col_q;
    pos_row = sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    v0_d    = 1'b0;
    if (in_valid) begin
      win_d = {col_t'{px_top, px_mid, px_bot}, win_q[2:1]};
      v0_d  = (pos_col >= CW'(2)) && (pos_row >= RW'(2));
      if (pos_col == CW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        if (pos_row == RW'(IMG_HEIGHT - 1)) begin
          row_d = '0;
        end else begin
          row_d = pos_row + 1'b1;
        end
      end else begin
        col_d = pos_col + 1'b1;
        row_d = pos_row;
      end
    end
  end

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      col_q <= '0;
      row_q <= '0;
      win_q <= '0;
      v0_q  <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      win_q <= win_d;
      v0_q  <= v0_d;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_s1
    sort3 u_sort (
      .a_i   (win_q[g].top),
      .b_i   (win_q[g].mid),
      .c_i   (win_q[g].bot),
      .min_o (s1_min_d[g]),
      .med_o (s1_med_d[g]),
      .max_o (s1_max_d[g])
    );
  end

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      s1_min_q <= '0;
      s1_med_q <= '0;
      s1_max_q <= '0;
      s1_cen_q <= '0;
      s1_v_q   <= 1'b0;
    end else begin
      s1_min_q <= s1_min_d;
      s1_med_q <= s1_med_d;
      s1_max_q <= s1_max_d;
      s1_cen_q <= win_q[1].mid;
      s1_v_q   <= v0_q;
    end
  end

  sort3 u_s2_mins (
    .a_i   (s1_min_q[0]),
    .b_i   (s1_min_q[1]),
    .c_i   (s1_min_q[2]),
    .min_o (unused_s2a_mn),
    .med_o (unused_s2a_md),
    .max_o (s2_lo_d)
  );

  sort3 u_s2_meds (
    .a_i   (s1_med_q[0]),
    .b_i   (s1_med_q[1]),
    .c_i   (s1_med_q[2]),
    .min_o (unused_s2b_mn),
    .med_o (s2_md_d),
    .max_o (unused_s2b_mx)
  );

  sort3 u_s2_maxs (
    .a_i   (s1_max_q[0]),
    .b_i   (s1_max_q[1]),
    .c_i   (s1_max_q[2]),
    .min_o (s2_hi_d),
    .med_o (unused_s2c_md),
    .max_o (unused_s2c_mx)
  );

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      s2_lo_q  <= '0;
      s2_md_q  <= '0;
      s2_hi_q  <= '0;
      s2_cen_q <= '0;
      s2_v_q   <= 1'b0;
    end else begin
      s2_lo_q  <= s2_lo_d;
      s2_md_q  <= s2_md_d;
      s2_hi_q  <= s2_hi_d;
      s2_cen_q <= s1_cen_q;
      s2_v_q   <= s1_v_q;
    end
  end

  sort3 u_s3 (
    .a_i   (s2_lo_q),
    .b_i   (s2_md_q),
    .c_i   (s2_hi_q),
    .min_o (unused_s3_mn),
    .med_o (s3_med_d),
    .max_o (unused_s3_mx)
  );

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      s3_med_q <= '0;
      s3_cen_q <= '0;
      s3_v_q   <= 1'b0;
    end else begin
      s3_med_q <= s3_med_d;
      s3_cen_q <= s2_cen_q;
      s3_v_q   <= s2_v_q;
    end
  end

  // clean centres pass through; only 0/255 take the median
  always_comb begin
    out_valid_d = s3_v_q;
    out_data_d  = out_data_q;
    if (s3_v_q) begin
      out_data_d = is_noise(s3_cen_q) ? s3_med_q : s3_cen_q;
    end
  end

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_median_window_filter.sv
// Scoreboard bench: 4x4 and 6x6 instances share one input stream.
module tb_median_window_filter;

  logic       clk = 1'b0;
  logic       nres = 1'b0;
  logic       in_valid = 1'b0;
  logic       sof = 1'b0;
  logic [7:0] px_top = '0;
  logic [7:0] px_mid = '0;
  logic [7:0] px_bot = '0;
  logic       ov4, ov6;
  logic [7:0] od4, od6;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] d;
    int         at;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] got0[$];
  logic [7:0] got1[$];
  int         pcol[2];
  int         prow[2];
  logic [7:0] hist[2][3][3];
  logic [7:0] last[2];

  median_window_filter #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
    .clk(clk), .nres(nres), .in_valid(in_valid), .sof(sof),
    .px_top(px_top), .px_mid(px_mid), .px_bot(px_bot),
    .out_valid(ov4), .out_data(od4)
  );

  median_window_filter #(.IMG_WIDTH(6), .IMG_HEIGHT(6)) dut6 (
    .clk(clk), .nres(nres), .in_valid(in_valid), .sof(sof),
    .px_top(px_top), .px_mid(px_mid), .px_bot(px_bot),
    .out_valid(ov6), .out_data(od6)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  function automatic logic [7:0] rpx();
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) return 8'd0;
    if (r == 1) return 8'd255;
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      pcol[i] = 0;
      prow[i] = 0;
      for (int k = 0; k < 3; k++)
        for (int j = 0; j < 3; j++) hist[i][k][j] = '0;
    end
  endtask

  // Reference: last three accepted columns, sort all nine, take the 5th.
  task automatic model_accept(input int i, input bit s,
                              input logic [7:0] t, m, b);
    int pc, pr, w, h;
    int a[$];
    logic [7:0] c;
    exp_t e;
    w = (i == 0) ? 4 : 6;
    h = w;
    pc = s ? 0 : pcol[i];
    pr = s ? 0 : prow[i];
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 3; j++) hist[i][k][j] = hist[i][k+1][j];
    hist[i][2][0] = t;
    hist[i][2][1] = m;
    hist[i][2][2] = b;
    if (pc >= 2 && pr >= 2) begin
      for (int k = 0; k < 3; k++)
        for (int j = 0; j < 3; j++) a.push_back(int'(hist[i][k][j]));
      a.sort();
      c = hist[i][1][1];
      e.d = (c == 8'd0 || c == 8'd255) ? 8'(a[4]) : c;
      e.at = cyc + 5;
      if (i == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    pc++;
    if (pc == w) begin
      pc = 0;
      pr++;
      if (pr == h) pr = 0;
    end
    pcol[i] = pc;
    prow[i] = pr;
  endtask

  task automatic drive(input bit v, input bit s,
                       input logic [7:0] t, m, b);
    @(negedge clk);
    in_valid = v;
    sof = s;
    px_top = t;
    px_mid = m;
    px_bot = b;
    if (v && nres) begin
      model_accept(0, s, t, m, b);
      model_accept(1, s, t, m, b);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      drive(1'b0, 1'($urandom_range(0, 1)), rpx(), rpx(), rpx());
  endtask

  task automatic mon_port(input int i, input logic v, input logic [7:0] d);
    exp_t e;
    int n;
    n = (i == 0) ? q0.size() : q1.size();
    if (n > 0) begin
      e = (i == 0) ? q0[0] : q1[0];
      if (e.at < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_out dut%0d: no pulse at edge %0d, required data %0d",
                 i, e.at, e.d);
        if (i == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
      end
    end
    if (v) begin
      n = (i == 0) ? q0.size() : q1.size();
      checks++;
      if (n == 0) begin
        failures++;
        $display("FAIL spurious_valid dut%0d: out_valid=1 data %0d at edge %0d, required none",
                 i, d, cyc);
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        if (d !== e.d || cyc != e.at) begin
          failures++;
          $display("FAIL result dut%0d: data %0d at edge %0d, required data %0d at edge %0d",
                   i, d, cyc, e.d, e.at);
        end
      end
      if (i == 0) got0.push_back(d);
      else got1.push_back(d);
      last[i] = d;
    end else begin
      checks++;
      if (d !== last[i]) begin
        failures++;
        $display("FAIL hold dut%0d: data %0d while idle, required %0d", i, d, last[i]);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!nres) begin
        last[0] = '0;
        last[1] = '0;
      end else begin
        mon_port(0, ov4, od4);
        mon_port(1, ov6, od6);
      end
    end
  end

  task automatic win_test(input string name,
                          input logic [7:0] w[9],
                          input int req);
    got0.delete();
    for (int k = 0; k < 8; k++) drive(1'b1, k == 0, rpx(), rpx(), rpx());
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, w[3*k], w[3*k+1], w[3*k+2]);
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, rpx(), rpx(), rpx());
    idle(6);
    chk({name, "_count"}, got0.size(), 4);
    chk(name, (got0.size() > 0) ? int'(got0[0]) : -1, req);
  endtask

  task automatic flat_frame(input bit gaps, input string name);
    got0.delete();
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, k == 0, 8'd100, 8'd100, 8'd100);
      if (gaps) drive(1'b0, 1'($urandom_range(0, 1)), rpx(), rpx(), rpx());
    end
    idle(6);
    chk({name, "_pulses"}, got0.size(), 4);
    for (int k = 0; k < 4; k++)
      chk({name, "_value"}, (k < got0.size()) ? int'(got0[k]) : -1, 100);
  endtask

  logic [7:0] w_salt[9]  = '{10, 40, 70, 20, 255, 80, 30, 60, 90};
  logic [7:0] w_clean[9] = '{10, 40, 70, 20, 50, 80, 30, 60, 90};
  logic [7:0] w_pep[9]   = '{200, 200, 200, 200, 0, 200, 200, 200, 200};

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_ov4", int'(ov4), 0);
    chk("reset_od4", int'(od4), 0);
    chk("reset_ov6", int'(ov6), 0);
    chk("reset_od6", int'(od6), 0);
    #2 nres = 1'b1;

    flat_frame(1'b0, "flat");
    flat_frame(1'b1, "gaps");

    win_test("salt", w_salt, 60);
    win_test("clean", w_clean, 50);
    win_test("pepper", w_pep, 200);

    for (int k = 0; k < 19; k++) drive(1'b1, k == 0, rpx(), rpx(), rpx());
    idle(6);
    got1.delete();
    for (int k = 0; k < 36; k++) drive(1'b1, k == 0, rpx(), rpx(), rpx());
    idle(6);
    chk("resync_count6", got1.size(), 16);

    for (int k = 0; k < 33; k++) drive(1'b1, k == 0, rpx(), rpx(), rpx());
    @(negedge clk);
    #2 nres = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midreset_ov4", int'(ov4), 0);
    chk("midreset_od4", int'(od4), 0);
    chk("midreset_ov6", int'(ov6), 0);
    chk("midreset_od6", int'(od6), 0);
    q0.delete();
    q1.delete();
    model_reset();
    repeat (2) @(negedge clk);
    #2 nres = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, rpx(), rpx(), rpx());
      chk("post_reset_ov4", int'(ov4), 0);
      chk("post_reset_ov6", int'(ov6), 0);
    end

    for (int n = 0; n < 3000; n++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0,
            rpx(), rpx(), rpx());

    idle(8);
    chk("drain_q4", q0.size(), 0);
    chk("drain_q6", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
